// File: rtl/branch_compare_pipe.sv
// branch_compare_pipe: two-stage pipelined MIPS branch comparator.
// Stage 1 registers the operands and the opcode; stage 2 registers the
// Taken/Zero/Sign flags together with OutValid.
// Optional feature macro: BRANCH_STATS_EN. When it is defined, the block
// keeps saturating retired and taken branch counters.
module branch_compare_pipe #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid,
    input  logic [WIDTH-1:0]     InA,
    input  logic [WIDTH-1:0]     InB,
    input  logic [2:0]           BranchOp,
    input  logic                 Stall,
    input  logic                 Flush,
    output logic                 OutValid,
    output logic                 Taken,
    output logic                 Zero,
    output logic                 Sign,
    output logic [CNT_WIDTH-1:0] TakenCount,
    output logic [CNT_WIDTH-1:0] BranchCount
);

    localparam int STAGES = 2;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'b000,
        OP_BNE  = 3'b001,
        OP_BLEZ = 3'b010,
        OP_BGTZ = 3'b011,
        OP_BLTZ = 3'b100,
        OP_BGEZ = 3'b101,
        OP_BLT  = 3'b110,
        OP_BGE  = 3'b111
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    typedef struct packed {
        logic taken;
        logic zero;
        logic sign;
    } res_t;

    // vld_pipe[0] is the stage-1 valid bit; vld_pipe[1] drives OutValid.
    logic [STAGES-1:0] vld_pipe;
    req_t              s1_req;
    res_t              s1_res;
    res_t              s2_res;
    logic [WIDTH:0]    diff;
    logic              zero_op;
    logic              cmp_zero;
    logic              cmp_sign;
    logic              cmp_taken;

    // Evaluate the condition from the stage-1 operands. The subtraction is
    // one bit wider than the operands so its top bit is the true signed
    // A<B result and no overflow correction is needed.
    always_comb begin
        diff      = {s1_req.a[WIDTH-1], s1_req.a} - {s1_req.b[WIDTH-1], s1_req.b};
        zero_op   = (s1_req.op inside {OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ});
        cmp_zero  = zero_op ? (s1_req.a == '0) : (s1_req.a == s1_req.b);
        cmp_sign  = zero_op ? s1_req.a[WIDTH-1] : diff[WIDTH];
        cmp_taken = 1'b0;
        case (s1_req.op)
            OP_BEQ:         cmp_taken = cmp_zero;
            OP_BNE:         cmp_taken = !cmp_zero;
            OP_BLEZ:        cmp_taken = cmp_sign | cmp_zero;
            OP_BGTZ:        cmp_taken = !cmp_sign & !cmp_zero;
            OP_BLTZ, OP_BLT: cmp_taken = cmp_sign;
            OP_BGEZ, OP_BGE: cmp_taken = !cmp_sign;
            default:        cmp_taken = 1'b0;
        endcase
        s1_res = '{taken: cmp_taken, zero: cmp_zero, sign: cmp_sign};
        // A bubble moving into stage 2 must present all-zero flags.
        if (!vld_pipe[0])
            s1_res = '0;
    end

    // Pipeline registers. Flush wins over Stall and clears both valid bits
    // and the result flags. Stall freezes every stage, including the
    // operand capture. The stage-1 operands are not cleared on flush
    // because their valid bit already masks them.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vld_pipe <= '0;
            s1_req   <= '0;
            s2_res   <= '0;
        end else if (Flush) begin
            vld_pipe <= '0;
            s2_res   <= '0;
        end else if (!Stall) begin
            vld_pipe <= {vld_pipe[0], InValid};
            s1_req   <= '{op: op_e'(BranchOp), a: InA, b: InB};
            s2_res   <= s1_res;
        end
    end

    assign OutValid = vld_pipe[STAGES-1];
    assign Taken    = s2_res.taken;
    assign Zero     = s2_res.zero;
    assign Sign     = s2_res.sign;

`ifdef BRANCH_STATS_EN
    logic                 retire;
    logic [CNT_WIDTH-1:0] taken_cnt;
    logic [CNT_WIDTH-1:0] branch_cnt;

    // A branch retires on the edge where stage 2 loads a valid result.
    assign retire = vld_pipe[0] && !Stall && !Flush;

    // Saturating statistics counters; only reset clears them.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            taken_cnt  <= '0;
            branch_cnt <= '0;
        end else if (retire) begin
            if (branch_cnt != '1)
                branch_cnt <= branch_cnt + CNT_WIDTH'(1);
            if (s1_res.taken && taken_cnt != '1)
                taken_cnt <= taken_cnt + CNT_WIDTH'(1);
        end
    end

    assign TakenCount  = taken_cnt;
    assign BranchCount = branch_cnt;
`else
    assign TakenCount  = '0;
    assign BranchCount = '0;
`endif

endmodule

// File: tb/tb_branch_compare_pipe.sv
// Self-checking bench for branch_compare_pipe. It checks table vectors and
// random vectors through a scoreboard, then runs hand-written stall, flush,
// reset and counter sequences.
module tb_branch_compare_pipe;

    localparam int W  = 32;
    localparam int CW = 2;

    localparam logic [2:0] BEQ = 3'd0, BNE = 3'd1, BLEZ = 3'd2, BGTZ = 3'd3,
                           BLTZ = 3'd4, BGEZ = 3'd5, BLT = 3'd6, BGE = 3'd7;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          InValid = 1'b0;
    logic [W-1:0]  InA = '0;
    logic [W-1:0]  InB = '0;
    logic [2:0]    BranchOp = '0;
    logic          Stall = 1'b0;
    logic          Flush = 1'b0;
    logic          OutValid, Taken, Zero, Sign;
    logic [CW-1:0] TakenCount, BranchCount;

    branch_compare_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InA(InA), .InB(InB),
        .BranchOp(BranchOp), .Stall(Stall), .Flush(Flush),
        .OutValid(OutValid), .Taken(Taken), .Zero(Zero), .Sign(Sign),
        .TakenCount(TakenCount), .BranchCount(BranchCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   tzs;   // expected {Taken, Zero, Sign}
    } vec_t;

    typedef struct {
        int         id;
        logic [2:0] tzs;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    bit   mon_en = 1'b0;

    // Reference model written from the branch definitions, using native
    // signed comparison.
    function automatic logic [2:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic t, z, s;
        if (op inside {BLEZ, BGTZ, BLTZ, BGEZ}) begin
            z = (a == 0);
            s = ($signed(a) < 0);
        end else begin
            z = (a == b);
            s = ($signed(a) < $signed(b));
        end
        case (op)
            BEQ:  t = z;
            BNE:  t = !z;
            BLEZ: t = s || z;
            BGTZ: t = !s && !z;
            BLTZ, BLT: t = s;
            default: t = !s;
        endcase
        return {t, z, s};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        InValid  = v;
        BranchOp = op;
        InA      = a;
        InB      = b;
    endtask

    task automatic chk_out(input string name, input logic [3:0] exp);
        nvec++;
        if ({OutValid, Taken, Zero, Sign} !== exp) begin
            nerr++;
            $display("FAIL %s: got v/t/z/s=%b expected %b", name,
                     {OutValid, Taken, Zero, Sign}, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [CW-1:0] et,
                           input logic [CW-1:0] eb);
        nvec++;
        if (TakenCount !== et || BranchCount !== eb) begin
            nerr++;
            $display("FAIL %s: got taken=%0d branch=%0d expected taken=%0d branch=%0d",
                     name, TakenCount, BranchCount, et, eb);
        end
    endtask

    // Scoreboard monitor: every OutValid cycle must match the oldest pending entry.
    always @(negedge Clk) begin
        if (mon_en && OutValid) begin
            nvec++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL sb_unexpected: got OutValid=1 expected no result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({Taken, Zero, Sign} !== e.tzs) begin
                    nerr++;
                    $display("FAIL sb_vec%0d: got t/z/s=%b expected %b", e.id,
                             {Taken, Zero, Sign}, e.tzs);
                end
            end
        end
    end

    task automatic drain(input string name);
        drive(0, BEQ, '0, '0);
        for (int c = 0; c < 10 && sb.size() != 0; c++) step();
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL %s: got %0d results missing expected 0", name, sb.size());
            sb.delete();
        end
        step();
    endtask

    initial begin
        vecs[0]  = '{BLT,  32'h8000_0000, 32'h0000_0001, 3'b101};
        vecs[1]  = '{BGE,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b100};
        vecs[2]  = '{BLEZ, 32'h0000_0000, 32'h1234_5678, 3'b110};
        vecs[3]  = '{BGTZ, 32'h0000_0005, 32'h0000_0000, 3'b100};
        vecs[4]  = '{BLTZ, 32'hFFFF_FFFF, 32'h0000_0000, 3'b101};
        vecs[5]  = '{BGEZ, 32'h0000_0000, 32'hFFFF_FFFF, 3'b110};
        vecs[6]  = '{BNE,  32'h0000_0003, 32'h0000_0003, 3'b010};
        vecs[7]  = '{BEQ,  32'h0000_0001, 32'h0000_0002, 3'b001};
        vecs[8]  = '{BGTZ, 32'h0000_0000, 32'h0000_0005, 3'b010};
        vecs[9]  = '{BLEZ, 32'h8000_0000, 32'h0000_0000, 3'b101};
        vecs[10] = '{BGE,  32'h8000_0000, 32'h7FFF_FFFF, 3'b001};
        vecs[11] = '{BLT,  32'hFFFF_FFFF, 32'h0000_0000, 3'b101};
        vecs[12] = '{BGTZ, 32'hFFFF_FFFF, 32'h0000_0001, 3'b001};
        vecs[13] = '{BGEZ, 32'h7FFF_FFFF, 32'h8000_0000, 3'b100};

        // Reset state before any clock edge.
        #1;
        chk_out("reset_state", 4'b0000);
        chk_cnt("reset_cnt", '0, '0);
        step();
        Rst = 1'b1;
        step();

        // Single BEQ: result two edges after sampling, then a bubble.
        drive(1, BEQ, 32'h0000_1234, 32'h0000_1234);
        step();
        drive(0, BEQ, '0, '0);
        @(negedge Clk) chk_out("beq_s1_only", 4'b0000);
        step();
        @(negedge Clk) chk_out("beq_result", 4'b1110);
        step();
        @(negedge Clk) chk_out("beq_bubble", 4'b0000);
        step();

        // Back-to-back table vectors through the scoreboard.
        mon_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(1, vecs[i].op, vecs[i].a, vecs[i].b);
            sb.push_back('{i, vecs[i].tzs});
            step();
        end
        drain("table_drain");

        // Random vectors, checked against the model. Idle cycles are mixed in.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom();
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
            if ($urandom_range(0, 4) == 0) drive(0, op, a, b);
            else begin
                drive(1, op, a, b);
                sb.push_back('{100 + i, model(op, a, b)});
            end
            step();
        end
        drain("random_drain");
        mon_en = 1'b0;

        // Stall with results in both stages: outputs frozen, then the next result exactly once.
        drive(1, BEQ, 32'd7, 32'd7);
        step();
        drive(1, BNE, 32'd1, 32'd2);
        step();
        drive(0, BEQ, '0, '0);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk) chk_out($sformatf("stall_hold%0d", i), 4'b1110);
            step();
        end
        @(negedge Clk) chk_out("stall_hold3", 4'b1110);
        Stall = 1'b0;
        step();
        @(negedge Clk) chk_out("stall_release", 4'b1101);
        step();
        @(negedge Clk) chk_out("stall_no_dup", 4'b0000);
        step();

        // Flush with Stall and InValid asserted squashes both stages and drops the input.
        drive(1, BEQ, 32'd9, 32'd9);
        step();
        drive(1, BLTZ, 32'hFFFF_0000, 32'd0);
        step();
        @(negedge Clk) chk_out("pre_flush", 4'b1110);
        drive(1, BEQ, '0, '0);
        Stall = 1'b1;
        Flush = 1'b1;
        step();
        Stall = 1'b0;
        Flush = 1'b0;
        drive(0, BEQ, '0, '0);
        @(negedge Clk) chk_out("flush_c1", 4'b0000);
        step();
        @(negedge Clk) chk_out("flush_c2", 4'b0000);
        step();
        @(negedge Clk) chk_out("flush_c3", 4'b0000);
        step();

        // Asynchronous reset mid-stream clears outputs without a clock edge.
        drive(1, BEQ, 32'd5, 32'd5);
        step();
        drive(1, BGEZ, 32'd1, 32'd0);
        step();
        drive(0, BEQ, '0, '0);
        @(negedge Clk) chk_out("pre_reset", 4'b1110);
        #2 Rst = 1'b0;
        #1 chk_out("async_reset", 4'b0000);
        chk_cnt("async_reset_cnt", '0, '0);
        step();
        Rst = 1'b1;
        step();
        @(negedge Clk) chk_out("post_reset", 4'b0000);
        step();

`ifdef BRANCH_STATS_EN
        // Three retired branches (two taken), then two inputs dropped by flush.
        drive(1, BEQ, 32'd1, 32'd1); step();
        drive(1, BNE, 32'd3, 32'd3); step();
        drive(1, BEQ, 32'd2, 32'd2); step();
        drive(0, BEQ, '0, '0); step(); step();
        Flush = 1'b1;
        drive(1, BEQ, 32'd4, 32'd4); step();
        drive(1, BEQ, 32'd6, 32'd6); step();
        Flush = 1'b0;
        drive(0, BEQ, '0, '0); step(); step();
        @(negedge Clk) chk_cnt("cnt_flush", 2'd2, 2'd3);
        step();
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        step();
        // Five taken BEQs saturate both counters.
        for (int i = 0; i < 5; i++) begin
            drive(1, BEQ, 32'(i), 32'(i));
            step();
        end
        drive(0, BEQ, '0, '0);
        step(); step();
        @(negedge Clk) chk_cnt("cnt_saturate", 2'd3, 2'd3);
        step();
`else
        for (int i = 0; i < 5; i++) begin
            drive(1, BEQ, 32'(i), 32'(i));
            step();
        end
        drive(0, BEQ, '0, '0);
        step(); step();
        @(negedge Clk) chk_cnt("cnt_tied_zero", '0, '0);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Watchdog so the bench always reaches its summary line.
    initial begin
        #200000;
        nerr++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1, "timeout");
    end

endmodule
